ecc_encoder: RTL and testbench
==============================

# ecc_encoder

Write-side ECC generator for the packet buffer. It sits directly upstream of the page SRAM and computes the 8-bit page check code that `ecc_decoder` verifies on read-out. It consumes one 128-bit page as eight 16-bit half-words (batches 0..7) and forwards the half-words to SRAM with one cycle of latency. In the cycle the last half-word is forwarded, it also presents the page's check code for storage alongside it.

## Interface
- `PAGE_AW`, default 11: page address width.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_batch`, in, 4: half-word index 0..7; 8 = idle. Values 9..15 are treated as 8.
- `in_data`, in, 16: write half-word.
- `in_page`, in, PAGE_AW: target page; sampled only with batch 0.
- `out_batch`, out, 4: forwarded index; 8 = idle.
- `out_data`, out, 16: forwarded half-word.
- `out_page`, out, PAGE_AW: page latched at batch 0.
- `ecc_code`, out, 8: page check code.
- `ecc_valid`, out, 1: one-cycle strobe; `ecc_code` and `out_page` are valid while it is high.
- `seq_err`, out, 1: one-cycle strobe on an illegal batch sequence.

## Operation
- Data bit index: d = 16·batch + bit, with d in 0..127.
- Code definition: `ecc_code[k]` = XOR of every data bit d for which bit k of (d+1) is 1, k = 0..7.
  - On read, the syndrome `code_diff` equals d+1 of a single flipped data bit.
- Accumulator:
  - `acc[7:0]` is cleared on batch 0 and XORed with contrib(batch, in_data) on every accepted batch.
  - The final code is acc ^ contrib(7, in_data), registered on batch 7.
- FSM states:
  - IDLE: batch 0 → ACC with expected = 1. Batch 1..7 → `seq_err`, input dropped. Batch 8 → stay.
  - ACC(expected e):
    - batch == e: accept; e+1.
    - batch == 7 == e: accept; raise `ecc_valid` next cycle; → IDLE.
    - batch 8: gap, hold state (gaps are allowed).
    - batch 0: `seq_err`, discard the partial page, restart with this half-word as the new batch 0.
    - any other value: `seq_err`, input dropped, → IDLE.
- Only accepted half-words are forwarded. Dropped cycles forward `out_batch` = 8.
- A partial page aborted by `seq_err` never raises `ecc_valid`. Downstream ignores its half-words because no code is committed.

## Timing
- Reset values: `out_batch` = 8, `out_data` = 0, `out_page` = 0, `ecc_code` = 0, `ecc_valid` = 0, `seq_err` = 0, FSM = IDLE, acc = 0.
- Reset asserted mid-page: the page is abandoned with no strobe.
- Forward latency is 1 cycle: `in_batch`/`in_data` at cycle t appear on `out_batch`/`out_data` at t+1.
- `ecc_valid` is high in the same cycle that `out_batch` = 7, so SRAM writes the last half-word and the code together.
- `seq_err` is registered and appears at t+1 for an offending input at t.
- Back-to-back pages are supported: batch 0 may follow batch 7 in the next cycle, giving full throughput of one page per 8 cycles.
- `ecc_code` holds its value until the next `ecc_valid`.

## Configuration
- `ECC_ERR_INJECT_EN`:
  - Defined: adds ports `inj_en` (in, 1) and `inj_pos` (in, 7), both sampled with batch 0. The forwarded data bit d = `inj_pos` of that page is inverted, while `ecc_code` is computed on the clean data. This gives a single-bit error the decoder must correct.
  - Undefined: the ports are absent and data is forwarded unmodified.

## Structure
- `ecc_pkg` holds:
  - `BATCH_IDLE` = 4'd8 and `BATCH_LAST` = 4'd7.
  - The FSM state enum.
  - Function `ecc_contrib(batch[2:0], data[15:0])` → 8-bit, shared with the decoder.
- No sub-module: the accumulator, FSM and forwarding register live in one module.

## Test plan
- All-zero page (batches 0..7, data 0) → `ecc_code` = 0x00; `ecc_valid` coincides with `out_batch` = 7.
- Page with only batch 0 bit 0 set → 0x01. Only batch 7 bit 14 set → 0x7F. Only batch 7 bit 15 set → 0x80.
- All-ones page → 0x80. Then repeat with idle gaps of 3 cycles between every batch → same code, and `ecc_valid` is delayed accordingly.
- Two back-to-back pages 0x0001 and 0xFFFF with distinct `in_page` values → two `ecc_valid` strobes 8 cycles apart, each carrying the correct `out_page`.
- Sequences 0,1,3 → `seq_err` with no `ecc_valid`. Sequences 0,1,0..7 → `seq_err` followed by a valid code for the restarted page. A lone batch 5 in IDLE → `seq_err`.
- `ECC_ERR_INJECT_EN` defined, `inj_pos` = 68 → batch 4 bit 4 of the forwarded data is inverted, `ecc_code` is unchanged, and the decoder output matches the original data.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the page ECC encoder/decoder pair: batch markers,
// encoder FSM states and the per-half-word check-code contribution.
package ecc_pkg;

    localparam logic [3:0] BATCH_IDLE = 4'd8;
    localparam logic [3:0] BATCH_LAST = 4'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } ecc_state_e;

    // Each set data bit d contributes (d+1) to the XOR, so a single flipped
    // bit shows up in the syndrome as its own position plus one.
    function automatic logic [7:0] ecc_contrib(input logic [2:0]  batch,
                                               input logic [15:0] data);
        logic [7:0] code;
        logic [7:0] pos;
        code = 8'd0;
        for (int b = 0; b < 16; b++) begin
            pos = {1'b0, batch, 4'(b)} + 8'd1;
            if (data[b]) begin
                code = code ^ pos;
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/ecc_encoder.sv
// Write-side page ECC generator: forwards eight half-words with one cycle of
// latency and emits the page check code alongside the last one.
// Optional build macro: ECC_ERR_INJECT_EN adds single-bit error injection.
module ecc_encoder
    import ecc_pkg::*;
#(
    parameter int PAGE_AW = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_batch,
    input  logic [15:0]        in_data,
    input  logic [PAGE_AW-1:0] in_page,
`ifdef ECC_ERR_INJECT_EN
    input  logic               inj_en,
    input  logic [6:0]         inj_pos,
`endif
    output logic [3:0]         out_batch,
    output logic [15:0]        out_data,
    output logic [PAGE_AW-1:0] out_page,
    output logic [7:0]         ecc_code,
    output logic               ecc_valid,
    output logic               seq_err
);

    ecc_state_e         state_q, state_d;
    logic [2:0]         exp_q, exp_d;
    logic [7:0]         acc_q, acc_d;
    logic [3:0]         out_batch_q, out_batch_d;
    logic [15:0]        out_data_q, out_data_d;
    logic [PAGE_AW-1:0] out_page_q, out_page_d;
    logic [7:0]         ecc_code_q, ecc_code_d;
    logic               ecc_valid_q, ecc_valid_d;
    logic               seq_err_q, seq_err_d;

    logic [3:0]         batch_s;
    logic [7:0]         contrib_s;
    logic [15:0]        flip_s;
    logic               start_s;
    logic               take_s;
    logic               err_s;

    // Out-of-range indices collapse to idle.
    assign batch_s   = (in_batch > BATCH_IDLE) ? BATCH_IDLE : in_batch;
    assign contrib_s = ecc_contrib(batch_s[2:0], in_data);

    // Sequence checker: classify the incoming index against the expected one.
    always_comb begin
        start_s = 1'b0;
        take_s  = 1'b0;
        err_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (batch_s == 4'd0) begin
                    start_s = 1'b1;
                end else if (batch_s != BATCH_IDLE) begin
                    err_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_ACC: begin
                if (batch_s == BATCH_IDLE) begin
                    take_s = 1'b0;
                end else if (batch_s == 4'd0) begin
                    // A fresh batch 0 aborts the partial page but is kept.
                    start_s = 1'b1;
                    err_s   = 1'b1;
                end else if (batch_s == {1'b0, exp_q}) begin
                    take_s = 1'b1;
                end else begin
                    err_s = 1'b1;
                end
            end
            default: begin
                err_s = 1'b0;
            end
        endcase
    end

`ifdef ECC_ERR_INJECT_EN
    logic       inj_en_q;
    logic [6:0] inj_pos_q;
    logic       inj_en_s;
    logic [6:0] inj_pos_s;

    // Injection settings apply to the page whose batch 0 is arriving now.
    always_comb begin
        inj_en_s  = start_s ? inj_en  : inj_en_q;
        inj_pos_s = start_s ? inj_pos : inj_pos_q;
        if (inj_en_s && (inj_pos_s[6:4] == batch_s[2:0])) begin
            flip_s = 16'd1 << inj_pos_s[3:0];
        end else begin
            flip_s = 16'd0;
        end
    end

    // Injection settings register, captured with batch 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inj_en_q  <= 1'b0;
            inj_pos_q <= 7'd0;
        end else if (start_s) begin
            inj_en_q  <= inj_en;
            inj_pos_q <= inj_pos;
        end else begin
            inj_en_q  <= inj_en_q;
            inj_pos_q <= inj_pos_q;
        end
    end
`else
    assign flip_s = 16'd0;
`endif

    // Next-state, accumulator and output staging.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        acc_d       = acc_q;
        out_batch_d = BATCH_IDLE;
        out_data_d  = out_data_q;
        out_page_d  = out_page_q;
        ecc_code_d  = ecc_code_q;
        ecc_valid_d = 1'b0;
        seq_err_d   = err_s;
        if (start_s) begin
            state_d     = ST_ACC;
            exp_d       = 3'd1;
            acc_d       = contrib_s;
            out_page_d  = in_page;
            out_batch_d = batch_s;
            out_data_d  = in_data ^ flip_s;
        end else if (take_s) begin
            out_batch_d = batch_s;
            out_data_d  = in_data ^ flip_s;
            acc_d       = acc_q ^ contrib_s;
            if (batch_s == BATCH_LAST) begin
                ecc_code_d  = acc_q ^ contrib_s;
                ecc_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                exp_d = exp_q + 3'd1;
            end
        end else if (err_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exp_q       <= 3'd0;
            acc_q       <= 8'd0;
            out_batch_q <= BATCH_IDLE;
            out_data_q  <= 16'd0;
            out_page_q  <= '0;
            ecc_code_q  <= 8'd0;
            ecc_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            acc_q       <= acc_d;
            out_batch_q <= out_batch_d;
            out_data_q  <= out_data_d;
            out_page_q  <= out_page_d;
            ecc_code_q  <= ecc_code_d;
            ecc_valid_q <= ecc_valid_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign out_batch = out_batch_q;
    assign out_data  = out_data_q;
    assign out_page  = out_page_q;
    assign ecc_code  = ecc_code_q;
    assign ecc_valid = ecc_valid_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_ecc_encoder.sv
// Scoreboard bench for ecc_encoder: a page-level reference model queues the
// expected forwarded words, codes and sequence errors; a monitor checks them.
module tb_ecc_encoder;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    in_batch;
    logic [15:0]   in_data;
    logic [AW-1:0] in_page;
    logic          inj_en;
    logic [6:0]    inj_pos;
    logic [3:0]    out_batch;
    logic [15:0]   out_data;
    logic [AW-1:0] out_page;
    logic [7:0]    ecc_code;
    logic          ecc_valid;
    logic          seq_err;

    ecc_encoder #(.PAGE_AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_batch  (in_batch),
        .in_data   (in_data),
        .in_page   (in_page),
`ifdef ECC_ERR_INJECT_EN
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
`endif
        .out_batch (out_batch),
        .out_data  (out_data),
        .out_page  (out_page),
        .ecc_code  (ecc_code),
        .ecc_valid (ecc_valid),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [19:0]      fwd_q[$];
    logic [7+AW:0]    code_q[$];
    logic             err_q[$];
    int               vtimes[$];

    // reference model state
    int            nxt = -1;
    logic [15:0]   words[8];
    logic [AW-1:0] mpage;
    logic          m_inj_en = 1'b0;
    int            m_inj_pos = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_code();
        logic [7:0] c;
        c = 8'd0;
        for (int d = 0; d < 128; d++)
            if (words[d / 16][d % 16]) c = c ^ 8'(d + 1);
        return c;
    endfunction

    function automatic logic [15:0] ref_flip(input int b);
        if (m_inj_en && (m_inj_pos / 16 == b)) return 16'd1 << (m_inj_pos % 16);
        return 16'd0;
    endfunction

    // Apply one input cycle and record what the encoder must produce for it.
    task automatic drive(input int b, input logic [15:0] data, input logic [AW-1:0] page);
        int bn;
        in_batch = 4'(b);
        in_data  = data;
        in_page  = page;
        bn = (b > 8) ? 8 : b;
        if (bn == 8) begin
        end else if (bn == 0) begin
            if (nxt != -1) err_q.push_back(1'b1);
            for (int i = 0; i < 8; i++) words[i] = 16'd0;
            words[0]  = data;
            mpage     = page;
            m_inj_en  = inj_en;
            m_inj_pos = int'(inj_pos);
            nxt       = 1;
            fwd_q.push_back({4'd0, data ^ ref_flip(0)});
        end else if (bn == nxt) begin
            words[bn] = data;
            fwd_q.push_back({4'(bn), data ^ ref_flip(bn)});
            if (bn == 7) begin
                code_q.push_back({ref_code(), mpage});
                nxt = -1;
            end else begin
                nxt++;
            end
        end else begin
            err_q.push_back(1'b1);
            nxt = -1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8, 16'($urandom), AW'($urandom));
    endtask

    task automatic send_page(input logic [15:0] w[8], input logic [AW-1:0] page, input int gap);
        for (int b = 0; b < 8; b++) begin
            drive(b, w[b], (b == 0) ? page : AW'($urandom));
            if (b != 7) idle(gap);
        end
    endtask

    task automatic expect_code(input string name, input logic [7:0] exp);
        idle(3);
        chk(name, {24'd0, ecc_code}, {24'd0, exp});
    endtask

    // Monitor: every presented output must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_batch != 4'd8) begin
                if (fwd_q.size() == 0) chk("fwd_extra", {12'd0, out_batch, out_data}, 32'hFFFFFFFF);
                else chk("fwd", {12'd0, out_batch, out_data}, {12'd0, fwd_q.pop_front()});
            end
            if (ecc_valid) begin
                vtimes.push_back(cyc);
                chk("valid_align", {28'd0, out_batch}, 32'd7);
                if (code_q.size() == 0) chk("code_extra", {13'd0, ecc_code, out_page}, 32'hFFFFFFFF);
                else chk("code", {13'd0, ecc_code, out_page}, {13'd0, code_q.pop_front()});
            end
            if (seq_err) begin
                if (err_q.size() == 0) chk("seq_err_extra", 32'd1, 32'd0);
                else chk("seq_err", 32'd1, {31'd0, err_q.pop_front()});
            end
        end
    end

    initial begin
        logic [15:0] w[8];
        int t0;
        rst_n = 1'b0; inj_en = 1'b0; inj_pos = 7'd0;
        in_batch = 4'd8; in_data = 16'd0; in_page = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_out_batch", {28'd0, out_batch}, 32'd8);
        chk("rst_out_data",  {16'd0, out_data}, 32'd0);
        chk("rst_out_page",  {21'd0, out_page}, 32'd0);
        chk("rst_ecc_code",  {24'd0, ecc_code}, 32'd0);
        chk("rst_ecc_valid", {31'd0, ecc_valid}, 32'd0);
        chk("rst_seq_err",   {31'd0, seq_err}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) w[i] = 16'd0;
        send_page(w, 11'h011, 0);
        expect_code("zero_page", 8'h00);
        w[0] = 16'h0001;
        send_page(w, 11'h022, 0);
        expect_code("b0_bit0", 8'h01);
        w[0] = 16'h0000; w[7] = 16'h4000;
        send_page(w, 11'h033, 0);
        expect_code("b7_bit14", 8'h7F);
        w[7] = 16'h8000;
        send_page(w, 11'h044, 0);
        expect_code("b7_bit15", 8'h80);
        for (int i = 0; i < 8; i++) w[i] = 16'hFFFF;
        send_page(w, 11'h055, 0);
        expect_code("all_ones", 8'h00 ^ 8'h80);
        send_page(w, 11'h066, 3);
        expect_code("all_ones_gap", 8'h80);

        // back-to-back pages: strobes exactly 8 cycles apart
        t0 = vtimes.size();
        for (int i = 0; i < 8; i++) w[i] = 16'h0001;
        send_page(w, 11'h1A5, 0);
        for (int i = 0; i < 8; i++) w[i] = 16'hFFFF;
        send_page(w, 11'h25A, 0);
        idle(3);
        chk("b2b_count", vtimes.size() - t0, 32'd2);
        if (vtimes.size() - t0 == 2) chk("b2b_spacing", vtimes[t0 + 1] - vtimes[t0], 32'd8);
        chk("b2b_hold", {24'd0, ecc_code}, 32'h80);

        // illegal sequences
        drive(0, 16'h1234, 11'h077); drive(1, 16'h5678, 0); drive(3, 16'h9ABC, 0);
        idle(3);
        drive(0, 16'h1111, 11'h078); drive(1, 16'h2222, 0);
        for (int b = 0; b < 8; b++) drive(b, 16'(b * 16'h0101), (b == 0) ? 11'h079 : 11'h000);
        idle(2);
        drive(5, 16'hAAAA, 0);
        idle(2);
        drive(0, 16'h0F0F, 11'h07A); drive(12, 16'h0, 0); drive(1, 16'h0F0F, 0);
        drive(9, 16'h0, 0); drive(7, 16'h0, 0);
        idle(2);

        // reset mid-page abandons the page
        drive(0, 16'hBEEF, 11'h07B); drive(1, 16'hCAFE, 0); drive(2, 16'hF00D, 0);
        idle(2);
        rst_n = 1'b0; nxt = -1;
        idle(2);
        rst_n = 1'b1;
        drive(3, 16'h0000, 0);
        idle(2);

`ifdef ECC_ERR_INJECT_EN
        for (int i = 0; i < 8; i++) w[i] = 16'd0;
        inj_en = 1'b1; inj_pos = 7'd68;
        drive(0, 16'd0, 11'h07C);
        inj_en = 1'b0; inj_pos = 7'd0;
        for (int b = 1; b < 8; b++) drive(b, 16'd0, 0);
        expect_code("inj_code_clean", 8'h00);
`endif

        // randomized pages, gaps and stray indices
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(3) != 0) begin
                for (int b = 0; b < 8; b++) w[b] = 16'($urandom);
                send_page(w, AW'($urandom), int'($urandom_range(2)));
            end else begin
                drive(int'($urandom_range(15)), 16'($urandom), AW'($urandom));
            end
        end
        idle(4);
        chk("fwd_drained", fwd_q.size(), 32'd0);
        chk("code_drained", code_q.size(), 32'd0);
        chk("err_drained", err_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
